// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light decoder: mode, step class, FSM state and
// the lamp patterns of the left, right and hazard sequences.
package tail_light_pkg;

    typedef enum logic [1:0] {
        ModeOff    = 2'd0,
        ModeLeft   = 2'd1,
        ModeRight  = 2'd2,
        ModeHazard = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        StepNone    = 3'd0,
        StepLeft    = 3'd1,
        StepRight   = 3'd2,
        StepHazard  = 3'd3,
        StepIllegal = 3'd4
    } step_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTrack  = 2'd1,
        StLocked = 2'd2
    } state_e;

    // Left lamps (L = LEDR[9:7]) fill from the inside out, then blank.
    localparam logic [2:0] LeftP0 = 3'b000;
    localparam logic [2:0] LeftP1 = 3'b001;
    localparam logic [2:0] LeftP2 = 3'b011;
    localparam logic [2:0] LeftP3 = 3'b111;

    // Right lamps (R = LEDR[2:0]) fill from the inside out, then blank.
    localparam logic [2:0] RightP0 = 3'b000;
    localparam logic [2:0] RightP1 = 3'b100;
    localparam logic [2:0] RightP2 = 3'b110;
    localparam logic [2:0] RightP3 = 3'b111;

    localparam logic [5:0] LampsOff = 6'b000000;
    localparam logic [5:0] LampsAll = 6'b111111;

    // Mode reported once a step class has locked.
    function automatic mode_e step_to_mode(input step_e s);
        mode_e m;
        m = ModeOff;
        unique case (s)
            StepLeft:   m = ModeLeft;
            StepRight:  m = ModeRight;
            StepHazard: m = ModeHazard;
            default:    m = ModeOff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tl_step_classifier.sv
// Combinational classifier for one lamp-pattern transition.
// Ports:
//   prev_i  previous {L,R} pattern
//   cur_i   current {L,R} pattern
//   step_o  StepNone when equal, otherwise LEFT / RIGHT / HAZARD / ILLEGAL
module tl_step_classifier
    import tail_light_pkg::*;
(
    input  logic [5:0] prev_i,
    input  logic [5:0] cur_i,
    output step_e      step_o
);

    logic [2:0] prev_l, prev_r, cur_l, cur_r;
    logic       left_ok, right_ok, hazard_ok;

    assign prev_l = prev_i[5:3];
    assign prev_r = prev_i[2:0];
    assign cur_l  = cur_i[5:3];
    assign cur_r  = cur_i[2:0];

    always_comb begin
        left_ok = (prev_r == 3'b000) && (cur_r == 3'b000) &&
                  (((prev_l == LeftP0) && (cur_l == LeftP1)) ||
                   ((prev_l == LeftP1) && (cur_l == LeftP2)) ||
                   ((prev_l == LeftP2) && (cur_l == LeftP3)) ||
                   ((prev_l == LeftP3) && (cur_l == LeftP0)));

        right_ok = (prev_l == 3'b000) && (cur_l == 3'b000) &&
                   (((prev_r == RightP0) && (cur_r == RightP1)) ||
                    ((prev_r == RightP1) && (cur_r == RightP2)) ||
                    ((prev_r == RightP2) && (cur_r == RightP3)) ||
                    ((prev_r == RightP3) && (cur_r == RightP0)));

        hazard_ok = ((prev_i == LampsOff) && (cur_i == LampsAll)) ||
                    ((prev_i == LampsAll) && (cur_i == LampsOff));

        step_o = StepIllegal;
        if (prev_i == cur_i) begin
            step_o = StepNone;
        end else if (left_ok) begin
            step_o = StepLeft;
        end else if (right_ok) begin
            step_o = StepRight;
        end else if (hazard_ok) begin
            step_o = StepHazard;
        end
    end

endmodule

// File: rtl/tail_light_decoder.sv
// Monitor for the tail-light controller: decodes the running mode from the six
// LED lines, flags illegal transitions and stuck-lit lamps, measures step period.
// Ports:
//   ADC_CLK_10  clock, rising edge       reset      synchronous, active-high
//   led_in      {L[2:0], R[2:0]}         mode       0 OFF,1 LEFT,2 RIGHT,3 HAZARD
//   mode_valid  mode is locked           err        one-cycle error pulse
//   stuck       lamps lit and frozen     err_count  saturating err pulse count
//   period      cycles between the last two pattern changes (saturating)
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int unsigned LOCK_STEPS = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             ADC_CLK_10,
    input  logic             reset,
    input  logic [5:0]       led_in,
    output logic [1:0]       mode,
    output logic             mode_valid,
    output logic             err,
    output logic             stuck,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned StepW = $clog2(LOCK_STEPS + 1);

    logic [5:0]       cur_q, prev_q;
    state_e           state_q, state_d;
    step_e            kind_q, kind_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d, step_inc;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
    logic [CNT_W-1:0] period_q, period_d;
    mode_e            mode_q, mode_d;
    logic             mode_valid_q, mode_valid_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;
    logic [7:0]       err_count_q, err_count_d;

    step_e            step;
    logic             change;

    tl_step_classifier u_classifier (
        .prev_i (prev_q),
        .cur_i  (cur_q),
        .step_o (step)
    );

    assign change   = (cur_q != prev_q);
    assign idle_inc = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
    assign step_inc = (step_cnt_q == StepW'(LOCK_STEPS)) ? step_cnt_q
                                                         : step_cnt_q + StepW'(1);

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        step_cnt_d   = step_cnt_q;
        idle_cnt_d   = idle_inc;
        period_d     = period_q;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        err_d        = 1'b0;
        stuck_d      = stuck_q;

        if (change) begin
            // idle_cnt counts cycles since the last change, so elapsed = idle_cnt + 1.
            idle_cnt_d = '0;
            period_d   = idle_inc;
            stuck_d    = 1'b0;
            if (step == StepIllegal) begin
                err_d        = 1'b1;
                state_d      = StIdle;
                mode_d       = ModeOff;
                mode_valid_d = 1'b0;
                step_cnt_d   = '0;
            end else if ((state_q != StIdle) && (step == kind_q)) begin
                step_cnt_d = step_inc;
                if (state_q == StTrack && step_inc == StepW'(LOCK_STEPS)) begin
                    state_d      = StLocked;
                    mode_d       = step_to_mode(kind_q);
                    mode_valid_d = 1'b1;
                end
            end else begin
                // New sequence (from IDLE or after a change of kind) restarts the lock count.
                state_d      = StTrack;
                kind_d       = step;
                step_cnt_d   = StepW'(1);
                mode_d       = ModeOff;
                mode_valid_d = 1'b0;
                if (LOCK_STEPS <= 1) begin
                    state_d      = StLocked;
                    mode_d       = step_to_mode(step);
                    mode_valid_d = 1'b1;
                end
            end
        end else if (idle_cnt_q == CNT_W'(TIMEOUT)) begin
            // idle_cnt passes TIMEOUT once per quiet spell, so this fires once.
            state_d    = StIdle;
            mode_d     = ModeOff;
            step_cnt_d = '0;
            if (cur_q == LampsOff) begin
                mode_valid_d = 1'b1;
            end else begin
                mode_valid_d = 1'b0;
                stuck_d      = 1'b1;
                err_d        = 1'b1;
            end
        end

        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hff)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            cur_q        <= '0;
            prev_q       <= '0;
            state_q      <= StIdle;
            kind_q       <= StepNone;
            step_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            period_q     <= '0;
            mode_q       <= ModeOff;
            mode_valid_q <= 1'b0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
            err_count_q  <= '0;
        end else begin
            cur_q        <= led_in;
            prev_q       <= cur_q;
            state_q      <= state_d;
            kind_q       <= kind_d;
            step_cnt_q   <= step_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            period_q     <= period_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            err_q        <= err_d;
            stuck_q      <= stuck_d;
            err_count_q  <= err_count_d;
        end
    end

    assign mode       = mode_q;
    assign mode_valid = mode_valid_q;
    assign err        = err_q;
    assign stuck      = stuck_q;
    assign err_count  = err_count_q;
    assign period     = period_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Directed bench for tail_light_decoder with hand-computed expectations.
module tb_tail_light_decoder;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [5:0]       led_in;
    logic [1:0]       mode;
    logic             mode_valid;
    logic             err;
    logic             stuck;
    logic [7:0]       err_count;
    logic [CNT_W-1:0] period;

    int n_checks;
    int n_errors;

    tail_light_decoder #(
        .LOCK_STEPS (4),
        .TIMEOUT    (16),
        .CNT_W      (CNT_W)
    ) dut (
        .ADC_CLK_10 (clk),
        .reset      (reset),
        .led_in     (led_in),
        .mode       (mode),
        .mode_valid (mode_valid),
        .err        (err),
        .stuck      (stuck),
        .err_count  (err_count),
        .period     (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_mode, input logic e_valid,
                             input logic e_err, input logic e_stuck, input logic [7:0] e_cnt);
        check_eq({tag, ".mode"}, 32'(mode), 32'(e_mode));
        check_eq({tag, ".valid"}, 32'(mode_valid), 32'(e_valid));
        check_eq({tag, ".err"}, 32'(err), 32'(e_err));
        check_eq({tag, ".stuck"}, 32'(stuck), 32'(e_stuck));
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(e_cnt));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        led_in   = 6'b000000;
        tick(2);
        check_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("reset.period", 32'(period), 32'd0);

        // Lamps off: OFF locks one edge after idle_cnt reaches TIMEOUT.
        reset = 1'b0;
        tick(16);
        check_eq("off.before", 32'(mode_valid), 32'd0);
        tick(1);
        check_all("off.locked", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(3);
        check_all("off.hold", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0);

        // LEFT sequence, 3 cycles per step.
        led_in = 6'b001000; tick(3);
        led_in = 6'b011000; tick(3);
        led_in = 6'b111000; tick(3);
        led_in = 6'b000000; tick(1);
        check_eq("left.pre", 32'(mode_valid), 32'd0);
        tick(1);
        check_all("left.lock", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        check_eq("left.period", 32'(period), 32'd3);

        // Locked LEFT, then an illegal jump.
        led_in = 6'b001000; tick(3);
        check_all("left.stay", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        led_in = 6'b000100; tick(2);
        check_all("illegal", 2'd0, 1'b0, 1'b1, 1'b0, 8'd1);
        tick(1);
        check_eq("illegal.pulse", 32'(err), 32'd0);

        // 000100 -> 000000 is also illegal.
        led_in = 6'b000000; tick(2);
        check_all("illegal2", 2'd0, 1'b0, 1'b1, 1'b0, 8'd2);

        // Hazard toggling every 2 cycles.
        led_in = 6'b111111; tick(2);
        led_in = 6'b000000; tick(2);
        led_in = 6'b111111; tick(2);
        check_eq("haz.pre", 32'(mode_valid), 32'd0);
        led_in = 6'b000000; tick(2);
        check_all("haz.lock", 2'd3, 1'b1, 1'b0, 1'b0, 8'd2);
        check_eq("haz.period", 32'(period), 32'd2);

        // Switch to the right sequence.
        led_in = 6'b000100; tick(2);
        check_all("right.first", 2'd0, 1'b0, 1'b0, 1'b0, 8'd2);
        led_in = 6'b000110; tick(2);
        led_in = 6'b000111; tick(2);
        check_eq("right.pre", 32'(mode_valid), 32'd0);
        led_in = 6'b000000; tick(2);
        check_all("right.lock", 2'd2, 1'b1, 1'b0, 1'b0, 8'd2);

        // 000000 -> 011000 is illegal; then hold it until stuck.
        led_in = 6'b011000; tick(2);
        check_all("stuck.illegal", 2'd0, 1'b0, 1'b1, 1'b0, 8'd3);
        tick(16);
        check_all("stuck.before", 2'd0, 1'b0, 1'b0, 1'b0, 8'd3);
        tick(1);
        check_all("stuck.fire", 2'd0, 1'b0, 1'b1, 1'b1, 8'd4);
        tick(1);
        check_all("stuck.pulse", 2'd0, 1'b0, 1'b0, 1'b1, 8'd4);
        tick(5);
        check_all("stuck.hold", 2'd0, 1'b0, 1'b0, 1'b1, 8'd4);
        led_in = 6'b111000; tick(2);
        check_all("stuck.clear", 2'd0, 1'b0, 1'b0, 1'b0, 8'd4);

        // Relock LEFT: 111->000 (2), 000->001 (3), 001->011 (4 -> locked).
        led_in = 6'b000000; tick(2);
        led_in = 6'b001000; tick(2);
        led_in = 6'b011000; tick(2);
        check_all("relock", 2'd1, 1'b1, 1'b0, 1'b0, 8'd4);

        // Reset mid-sequence while LOCKED.
        led_in = 6'b000000;
        reset  = 1'b1;
        tick(1);
        check_all("midreset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("midreset.period", 32'(period), 32'd0);
        reset  = 1'b0;
        led_in = 6'b001000; tick(2);
        check_eq("post.period", 32'(period), 32'd2);
        check_eq("post.valid1", 32'(mode_valid), 32'd0);
        led_in = 6'b011000; tick(2);
        led_in = 6'b111000; tick(2);
        check_eq("post.valid3", 32'(mode_valid), 32'd0);
        led_in = 6'b000000; tick(2);
        check_all("post.lock", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tail_light_decoder.md
# tail_light_decoder

Receive-side companion to the lab3 tail-light controller: watches the six tail-light LED lines and decodes the running mode as OFF, LEFT, RIGHT or HAZARD. Flags illegal pattern transitions and stuck-lit lamps, and measures the step period. Sits on the same ADC_CLK_10 domain as the controller and serves as a self-checking monitor in lab builds and benches.

## Interface
- LOCK_STEPS, 4: consecutive legal steps of one kind needed to assert a mode
- TIMEOUT, 16: cycles without a pattern change before the idle/stuck check fires
- CNT_W, 16: width of period and idle counters
- ADC_CLK_10  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- led_in  in  6  {L[2:0], R[2:0]}; L = LEDR[9:7], R = LEDR[2:0]
- mode  out  2  0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD
- mode_valid  out  1  mode is locked
- err  out  1  one-cycle pulse on an illegal transition or stuck-lit timeout
- stuck  out  1  level, lamps lit with no change for TIMEOUT cycles
- err_count  out  8  saturating count of err pulses
- period  out  CNT_W  cycles between the last two pattern changes, saturating

## Operation
- Registers: cur <= led_in every cycle; prev <= cur. A change occurs when cur != prev.
- Step classification on a change (prev -> cur):
  - LEFT: R stays 000 and L steps 000->001->011->111->000.
  - RIGHT: L stays 000 and R steps 000->100->110->111->000.
  - HAZARD: {L,R} toggles 000000 <-> 111111.
  - Anything else is ILLEGAL. The classes are disjoint by construction.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE to TRACK: first legal step. Set kind = its class and step_cnt = 1.
  - TRACK, legal step of the same kind: step_cnt++. When step_cnt reaches LOCK_STEPS, go to LOCKED, set mode = kind and mode_valid = 1.
  - TRACK or LOCKED, legal step of a different kind: go to TRACK with the new kind, step_cnt = 1, mode_valid = 0, mode = OFF.
  - LOCKED, legal step of the same kind: stay in LOCKED. step_cnt saturates.
  - Any state, ILLEGAL step: pulse err, go to IDLE, mode = OFF, mode_valid = 0, step_cnt = 0.
- idle_cnt clears on every change and otherwise increments, saturating.
- When idle_cnt reaches TIMEOUT:
  - If cur == 000000: go to IDLE, mode = OFF, mode_valid = 1 (lamps genuinely off).
  - Otherwise: stuck = 1, pulse err once, go to IDLE, mode_valid = 0.
  - stuck clears on the next change.
- period: on each change, load the cycles elapsed since the previous change, saturating at all-ones. The first change after reset loads elapsed cycles since reset.
- err_count increments on each err pulse and saturates at 255.

## Timing
- Reset values: mode = 0, mode_valid = 0, err = 0, stuck = 0, err_count = 0, period = 0. cur, prev and all counters are 0, and the FSM is in IDLE.
- Latency: a pin change at edge k is captured in cur at k. Classification uses cur vs prev combinationally, and all outputs update at edge k+1.
- err is high for exactly one cycle per event. Back-to-back illegal changes give back-to-back pulses.
- Change and timeout in the same cycle: the change wins and idle_cnt clears.
- reset asserted mid-sequence returns every register to its reset value on that edge. reset overrides all other events.
- A repeated identical pattern is not a change and only advances idle_cnt.

## Structure
- Package tail_light_pkg holds:
  - the mode encoding (OFF/LEFT/RIGHT/HAZARD)
  - the step class encoding (NONE, LEFT, RIGHT, HAZARD, ILLEGAL)
  - the FSM state encoding
  - pattern constants for the left, right and hazard sequences
- One sub-module, tl_step_classifier: purely combinational, taking (prev, cur) and returning a step class. Unit-testable in isolation.
- All counters and the FSM live in tail_light_decoder.

## Test plan
- Reset, then led_in = 000000 held 20 cycles -> mode = OFF, mode_valid = 1 at cycle TIMEOUT+1, err = 0.
- L = 000,001,011,111,000 with 3 cycles per step -> mode = LEFT, mode_valid = 1 one cycle after the 4th change, period = 3.
- Locked LEFT, then led_in jumps 001000 -> 000100 -> err pulse of 1 cycle, mode = OFF, mode_valid = 0, err_count = 1.
- {L,R} alternating 000000/111111 every 2 cycles -> HAZARD after 4 changes. Then switch to the right sequence -> mode_valid = 0 on the first right step and RIGHT after 4 steps.
- Hold 011000 for 16 cycles -> stuck = 1, one err pulse. A later legal change clears stuck.
- Assert reset mid-sequence while LOCKED -> all outputs return to reset values on that edge, and the FSM relocks only after 4 fresh steps.
